// File: rtl/taiga_types.sv
// Shared types for the iterative divider.
package taiga_types;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIN
  } div_state_t;

endpackage

// File: rtl/div_clz.sv
// Combinational leading-zero count; an all-zero input yields WIDTH.
module div_clz #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]               i_value,
  output logic [$clog2(WIDTH+1)-1:0]     o_count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_value[i]) o_count = CW'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/div_unsigned_radix2.sv
// Unsigned radix-2 restoring divider with leading-zero skip and one-cycle divide-by-zero.
module div_unsigned_radix2
  import taiga_types::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  divisor_is_zero
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  div_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [CW-1:0]         r_count;

  logic [CW-1:0]         w_lz;
  logic [DATA_WIDTH:0]   w_t;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_q_next;

  div_clz #(.WIDTH(DATA_WIDTH)) u_clz (
    .i_value (dividend),
    .o_count (w_lz)
  );

  // One restoring step; compare at DATA_WIDTH+1 bits so the shifted-in bit never overflows.
  always_comb begin
    w_t        = {r_rem, r_work[DATA_WIDTH-1]};
    w_qbit     = (w_t >= {1'b0, r_divisor});
    w_rem_next = w_qbit ? DATA_WIDTH'(w_t - {1'b0, r_divisor}) : w_t[DATA_WIDTH-1:0];
    w_q_next   = {r_q[DATA_WIDTH-2:0], w_qbit};
  end

  // A start in any state (including RUN or FIN) loads the new operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= DIV_IDLE;
      r_work          <= '0;
      r_rem           <= '0;
      r_q             <= '0;
      r_divisor       <= '0;
      r_count         <= '0;
      quotient        <= '0;
      remainder       <= '0;
      done            <= 1'b0;
      divisor_is_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        divisor_is_zero <= 1'b0;
        r_divisor       <= divisor;
        if (divisor == '0) begin
          r_state         <= DIV_FIN;
          quotient        <= '1;
          remainder       <= dividend;
          divisor_is_zero <= 1'b1;
          done            <= 1'b1;
        end else if (dividend == '0) begin
          r_state   <= DIV_FIN;
          quotient  <= '0;
          remainder <= '0;
          done      <= 1'b1;
        end else begin
          r_state <= DIV_RUN;
          r_work  <= dividend << w_lz;
          r_rem   <= '0;
          r_q     <= '0;
          r_count <= CW'(DATA_WIDTH) - w_lz - CW'(1);
        end
      end else begin
        case (r_state)
          DIV_RUN: begin
            r_rem  <= w_rem_next;
            r_q    <= w_q_next;
            r_work <= r_work << 1;
            if (r_count == '0) begin
              r_state   <= DIV_FIN;
              quotient  <= w_q_next;
              remainder <= w_rem_next;
              done      <= 1'b1;
            end else begin
              r_count <= r_count - CW'(1);
            end
          end
          DIV_FIN: r_state <= DIV_IDLE;
          default: r_state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unsigned_radix2.sv
// Self-checking bench for div_unsigned_radix2 against an arithmetic reference model.
module tb_div_unsigned_radix2;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         divisor_is_zero;

  int n_cmp;
  int n_err;

  div_unsigned_radix2 #(.DATA_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .quotient        (quotient),
    .remainder       (remainder),
    .done            (done),
    .divisor_is_zero (divisor_is_zero)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V divide semantics; latency is 1 for trivial cases, else significant bits + 1.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    longint unsigned av;
    int nbits;
    av = longint'(a);
    nbits = 0;
    while ((av >> nbits) != 0) nbits++;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
      lat = (a == 0) ? 1 : nbits + 1;
    end
  endfunction

  // Called at a negedge; start is sampled by the following posedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; lat = -1 on timeout.
  task automatic wait_done(output int lat);
    bit got;
    got = 0; lat = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) got = 1;
    end
    if (!got) lat = -1;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    logic [W-1:0] eq, er; logic edz; int elat;
    model(a, b, eq, er, edz, elat);
    n_cmp++;
    if (lat !== elat || quotient !== eq || remainder !== er || divisor_is_zero !== edz) begin
      n_err++;
      $display("FAIL %s: %0d/%0d got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
               name, a, b, quotient, remainder, divisor_is_zero, lat, eq, er, edz, elat);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (quotient !== '0 || remainder !== '0 || done !== 1'b0 || divisor_is_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: q=%h r=%h done=%b dz=%b, want all 0", quotient, remainder, done, divisor_is_zero);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_done: done=%b at idle cycle %0d, want 0", done, i);
      end
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    int lat;
    ta = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd9, 32'd0, 32'd3, 32'd1};
    tb = '{32'd7,   32'd1,         32'hFFFF_FFFF, 32'd0, 32'd3, 32'd9, 32'd10, 32'd1};
    for (int i = 0; i < 8; i++) begin
      launch(ta[i], tb[i]);
      wait_done(lat);
      check_op("directed", ta[i], tb[i], lat);
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_width: done=%b one cycle after done, want 0", done);
      end
    end
  endtask

  task automatic test_abort_and_rst;
    int lat;
    int ndone;
    launch(32'h8000_0000, 32'd3);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    // This negedge is in cycle T+5.
    @(negedge clk);
    if (done === 1'b1) ndone++;
    launch(32'd20, 32'd6);
    wait_done(lat);
    check_op("abort_restart", 32'd20, 32'd6, lat);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL abort_single_done: extra done pulses=%0d, want 0", ndone);
    end

    launch(32'h8000_0000, 32'd3);
    ndone = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (quotient !== '0 || remainder !== '0 || done !== 1'b0 || divisor_is_zero !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: q=%h r=%h done=%b dz=%b, want all 0", quotient, remainder, done, divisor_is_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone !== 0 || quotient !== '0 || remainder !== '0) begin
      n_err++;
      $display("FAIL rst_mid_run: done pulses=%0d q=%h r=%h, want 0 0 0", ndone, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    int lat;
    a = $urandom >> $urandom_range(0, 31);
    b = $urandom >> $urandom_range(0, 31);
    launch(a, b);
    for (int i = 0; i < 20; i++) begin
      wait_done(lat);
      check_op("back_to_back", a, b, lat);
      a = ($urandom_range(0, 5) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      b = ($urandom_range(0, 5) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      launch(a, b);
    end
    wait_done(lat);
    check_op("back_to_back", a, b, lat);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic edz;
    int elat, lat, gap;
    for (int n = 0; n < 1500; n++) begin
      a = ($urandom_range(0, 15) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      b = ($urandom_range(0, 15) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) b = 32'd1;
      model(a, b, eq, er, edz, elat);
      launch(a, b);
      wait_done(lat);
      check_op("random", a, b, lat);
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || quotient !== eq || remainder !== er || divisor_is_zero !== edz) begin
          n_err++;
          $display("FAIL hold_stable: done=%b q=%h r=%h dz=%b, want 0 %h %h %b", done, quotient, remainder, divisor_is_zero, eq, er, edz);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_abort_and_rst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
